// File: rtl/plot_framebuffer.sv
// ============================================================================
// Module   : plot_framebuffer
// Purpose  : 160x120x3 frame store written by the pixel-plot port, with a
//            clear engine and a raster scan-out stream (1-cycle read latency).
//            Optional macro PLOT_DROP_COUNT_EN builds the rejected-plot counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module plot_framebuffer #(
    parameter int H_RES   = 160,
    parameter int V_RES   = 120,
    parameter int H_BLANK = 40,
    parameter int V_BLANK = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] vga_x,
    input  logic [6:0] vga_y,
    input  logic [2:0] vga_colour,
    input  logic       vga_plot,
    input  logic       clear_start,
    input  logic [2:0] clear_colour,
    output logic       clear_done,
    output logic       busy,
    input  logic       scan_en,
    output logic [7:0] px_x,
    output logic [6:0] px_y,
    output logic [2:0] px_colour,
    output logic       px_valid,
    output logic       frame_start,
    output logic [7:0] drop_count
);

    localparam int FRAME_PIX = H_RES * V_RES;
    localparam int AW        = $clog2(FRAME_PIX);

    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_PIX - 1);
    localparam logic [7:0]    H_LAST    = 8'(H_RES + H_BLANK - 1);
    localparam logic [6:0]    V_LAST    = 7'(V_RES + V_BLANK - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    function automatic logic [AW-1:0] addr_of(input logic [6:0] y, input logic [7:0] x);
        return AW'(int'(y) * H_RES + int'(x));
    endfunction

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic [2:0]    clr_colour_q, clr_colour_d;
    logic [7:0]    hcnt_q, hcnt_d;
    logic [6:0]    vcnt_q, vcnt_d;
    logic [7:0]    px_x_q, px_x_d;
    logic [6:0]    px_y_q, px_y_d;
    logic          px_valid_q, px_valid_d;
    logic          frame_start_q, frame_start_d;
    logic          px_seen_q, px_seen_d;

    logic [2:0]    mem [FRAME_PIX];
    logic [2:0]    rd_data_q;

    logic          plot_ok;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [2:0]    mem_wdata;
    logic          rd_en;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            clr_addr_q    <= '0;
            clr_colour_q  <= '0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            px_x_q        <= '0;
            px_y_q        <= '0;
            px_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
            px_seen_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_addr_q    <= clr_addr_d;
            clr_colour_q  <= clr_colour_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            px_x_q        <= px_x_d;
            px_y_q        <= px_y_d;
            px_valid_q    <= px_valid_d;
            frame_start_q <= frame_start_d;
            px_seen_q     <= px_seen_d;
        end
    end

    // Clear FSM next state
    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        clr_colour_d = clr_colour_q;
        case (state_q)
            S_IDLE: begin
                if (clear_start) begin
                    state_d      = S_CLEAR;
                    clr_addr_d   = '0;
                    clr_colour_d = clear_colour;
                end
            end
            S_CLEAR: begin
                if (clr_addr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            S_DONE: begin
                if (!clear_start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Clear FSM outputs
    always_comb begin
        busy       = (state_q == S_CLEAR);
        clear_done = (state_q == S_DONE);
    end

    // The clear engine owns the write port while it runs; plots then drop.
    always_comb begin
        plot_ok   = vga_plot && (state_q != S_CLEAR) &&
                    (int'(vga_x) < H_RES) && (int'(vga_y) < V_RES);
        mem_we    = (state_q == S_CLEAR) || plot_ok;
        mem_waddr = (state_q == S_CLEAR) ? clr_addr_q : addr_of(vga_y, vga_x);
        mem_wdata = (state_q == S_CLEAR) ? clr_colour_q : vga_colour;
    end

    // Scan counters and presentation registers
    always_comb begin
        rd_en  = scan_en && (int'(hcnt_q) < H_RES) && (int'(vcnt_q) < V_RES);
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (scan_en) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? 7'd0 : vcnt_q + 7'd1;
            end else begin
                hcnt_d = hcnt_q + 8'd1;
            end
        end
        px_valid_d    = rd_en;
        px_x_d        = rd_en ? hcnt_q : px_x_q;
        px_y_d        = rd_en ? vcnt_q : px_y_q;
        frame_start_d = rd_en && (hcnt_q == 8'd0) && (vcnt_q == 7'd0);
        px_seen_d     = px_seen_q || rd_en;
    end

    // Memory keeps no reset; non-blocking read gives read-before-write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (rd_en) begin
            rd_data_q <= mem[addr_of(vcnt_q, hcnt_q)];
        end
    end

    assign px_x        = px_x_q;
    assign px_y        = px_y_q;
    assign px_valid    = px_valid_q;
    assign frame_start = frame_start_q;
    assign px_colour   = px_seen_q ? rd_data_q : 3'd0;

`ifdef PLOT_DROP_COUNT_EN
    logic       plot_drop;
    logic [7:0] drop_count_q, drop_count_d;

    always_comb begin
        plot_drop    = vga_plot && !plot_ok;
        drop_count_d = drop_count_q;
        if (plot_drop && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`else
    assign drop_count = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_plot_framebuffer.sv
// ============================================================================
// Module   : tb_plot_framebuffer
// Purpose  : Scoreboard bench for plot_framebuffer: clear, plot, scan-out,
//            drop counting, and reset during a clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_plot_framebuffer;

`ifdef PLOT_DROP_COUNT_EN
    localparam int EXP_DROP2 = 2;
    localparam int EXP_SAT   = 255;
`else
    localparam int EXP_DROP2 = 0;
    localparam int EXP_SAT   = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] vga_x = '0;
    logic [6:0] vga_y = '0;
    logic [2:0] vga_colour = '0;
    logic       vga_plot = 1'b0;
    logic       clear_start = 1'b0;
    logic [2:0] clear_colour = '0;
    logic       clear_done;
    logic       busy;
    logic       scan_en = 1'b0;
    logic [7:0] px_x;
    logic [6:0] px_y;
    logic [2:0] px_colour;
    logic       px_valid;
    logic       frame_start;
    logic [7:0] drop_count;

    plot_framebuffer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour),
        .vga_plot     (vga_plot),
        .clear_start  (clear_start),
        .clear_colour (clear_colour),
        .clear_done   (clear_done),
        .busy         (busy),
        .scan_en      (scan_en),
        .px_x         (px_x),
        .px_y         (px_y),
        .px_colour    (px_colour),
        .px_valid     (px_valid),
        .frame_start  (frame_start),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t       exp_q[$];
    pix_t       mon_e;
    logic [2:0] shadow [19200];
    int         checks = 0;
    int         failures = 0;
    int         h_m = 0;
    int         v_m = 0;
    int         adv = 0;
    int         prev_fs_adv = -1;
    int         valid_cnt = 0;
    logic [7:0] last_x = '0;
    logic [6:0] last_y = '0;
    logic [2:0] last_c = '0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n && scan_en) adv++;
    end

    // Monitor: pops an expected pixel for every presented one.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_x = '0;
            last_y = '0;
            last_c = '0;
        end else if (px_valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_px", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("px_x", int'(px_x), int'(mon_e.x));
                check("px_y", int'(px_y), int'(mon_e.y));
                check("px_colour", int'(px_colour), int'(mon_e.c));
                check("frame_start", int'(frame_start), int'(mon_e.x == 0 && mon_e.y == 0));
            end
            if (frame_start) begin
                if (prev_fs_adv >= 0) check("frame_period", adv - prev_fs_adv, 25000);
                prev_fs_adv = adv;
            end
            last_x = px_x;
            last_y = px_y;
            last_c = px_colour;
        end else begin
            check("frame_start_idle", int'(frame_start), 0);
            check("hold_x", int'(px_x), int'(last_x));
            check("hold_y", int'(px_y), int'(last_y));
            check("hold_colour", int'(px_colour), int'(last_c));
        end
    end

    task automatic plot(input int x, input int y, input logic [2:0] c);
        @(posedge clk); #1;
        vga_x = 8'(x);
        vga_y = 7'(y);
        vga_colour = c;
        vga_plot = 1'b1;
        if (x < 160 && y < 120) shadow[y*160 + x] = c;
        @(posedge clk); #1;
        vga_plot = 1'b0;
    endtask

    // Returns early (clear still running) when abort_at >= 0.
    task automatic do_clear(input logic [2:0] col, input int plot_n, input int abort_at);
        int  busy_n = 0;
        bit  done = 1'b0;
        @(posedge clk); #1;
        clear_start  = 1'b1;
        clear_colour = col;
        vga_x = 8'd10;
        vga_y = 7'd10;
        vga_colour = 3'b111;
        for (int k = 0; k < 25000; k++) begin
            @(posedge clk); #1;
            clear_colour = ~col;
            if (abort_at >= 0 && k == abort_at) begin
                vga_plot = 1'b0;
                return;
            end
            if (clear_done) begin
                done = 1'b1;
                break;
            end
            if (busy) busy_n++;
            vga_plot = (k < plot_n);
        end
        vga_plot = 1'b0;
        check("clear_done", int'(done), 1);
        check("busy_cycles", busy_n, 19200);
        for (int i = 0; i < 19200; i++) shadow[i] = col;
        clear_start = 1'b0;
        @(posedge clk); #1;
        check("clear_done_fall", int'(clear_done), 0);
    endtask

    task automatic scan(input int n, input bit gappy);
        int   k = 0;
        int   i = 0;
        pix_t p;
        while (k < n) begin
            @(posedge clk); #1;
            if (gappy && (i % 50) == 7) begin
                scan_en = 1'b0;
            end else begin
                scan_en = 1'b1;
                if (h_m < 160 && v_m < 120) begin
                    p.x = 8'(h_m);
                    p.y = 7'(v_m);
                    p.c = shadow[v_m*160 + h_m];
                    exp_q.push_back(p);
                end
                h_m++;
                if (h_m == 200) begin
                    h_m = 0;
                    v_m = (v_m == 124) ? 0 : v_m + 1;
                end
                k++;
            end
            i++;
        end
        @(posedge clk); #1;
        scan_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("scan_queue_empty", exp_q.size(), 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_clear_done"}, int'(clear_done), 0);
        check({tag, "_px_valid"}, int'(px_valid), 0);
        check({tag, "_frame_start"}, int'(frame_start), 0);
        check({tag, "_px_x"}, int'(px_x), 0);
        check({tag, "_px_y"}, int'(px_y), 0);
        check({tag, "_px_colour"}, int'(px_colour), 0);
        check({tag, "_drop_count"}, int'(drop_count), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;

        do_clear(3'b001, 0, -1);
        check("drop_after_clear", int'(drop_count), 0);

        plot(27, 37, 3'b100);
        plot(159, 119, 3'b010);
        plot(165, 35, 3'b111);
        plot(27, 123, 3'b111);
        repeat (2) @(posedge clk);
        #1;
        check("drop_out_of_range", int'(drop_count), EXP_DROP2);

        valid_cnt = 0;
        scan(25000, 1'b0);
        check("valid_per_frame_1", valid_cnt, 19200);

        do_clear(3'b110, 300, 1000);
        check("busy_mid_clear", int'(busy), 1);
        check("drop_saturated_1", int'(drop_count), EXP_SAT);
        rst_n = 1'b0;
        clear_start = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        h_m = 0;
        v_m = 0;

        do_clear(3'b110, 300, -1);
        check("drop_saturated_2", int'(drop_count), EXP_SAT);

        valid_cnt = 0;
        scan(25000, 1'b1);
        check("valid_per_frame_2", valid_cnt, 19200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
